mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised N-channel memory port arbiter for the RV32IC core and its successors.
- Merges the core's separate instruction and data ports, plus optional extra masters (debug, DMA), onto one shared memory bus.
- Adds valid/ready request handshakes, variable-latency responses and a selectable arbitration mode.
- Sits between the core top level and the single-ported system memory.

Parameters:
XLEN, 32, address/data width in bits
NUM_PORTS, 2, number of requesting channels (>=2); port 0 = instruction fetch, port 1 = data
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_PORTS  per-channel request valid
req_ready  output  NUM_PORTS  per-channel accept; one-hot, single-cycle pulse
req_we  input  NUM_PORTS  per-channel write enable
req_addr  input  NUM_PORTS*XLEN  flattened addresses, channel i at [i*XLEN +: XLEN]
req_wdata  input  NUM_PORTS*XLEN  flattened write data
req_wstrb  input  NUM_PORTS*XLEN/8  flattened byte strobes
resp_valid  output  NUM_PORTS  one-hot, single-cycle response pulse to the granted channel
resp_rdata  output  XLEN  read data, broadcast to all channels; qualify with resp_valid
mem_valid  output  1  downstream request valid
mem_ready  input  1  downstream request accept
mem_we  output  1  downstream write enable
mem_addr  output  XLEN  downstream address
mem_wdata  output  XLEN  downstream write data
mem_wstrb  output  XLEN/8  downstream byte strobes
mem_rvalid  input  1  downstream response (read data or write ack)
mem_rdata  input  XLEN  downstream read data

Behaviour:
- One outstanding transaction at a time. FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid bit is set, select grant g.
  - Fixed mode: lowest set index.
  - RR mode: first set index at or after rr_ptr, wrapping modulo NUM_PORTS.
  - Drive req_ready[g]=1 combinationally in the same cycle.
  - Latch we/addr/wdata/wstrb of channel g and g into registers; next state ISSUE.
  - No req_valid set: stay in IDLE.
- ISSUE:
  - mem_valid=1; mem_* driven from the latched registers, stable until accepted.
  - mem_ready=1: next state WAIT. Otherwise remain in ISSUE.
- WAIT:
  - mem_valid=0.
  - On mem_rvalid=1: resp_valid[g]=1 for that cycle; resp_rdata=mem_rdata passed combinationally.
  - Writes also complete on mem_rvalid; rdata is don't-care for writes.
  - RR mode: rr_ptr <= (g+1) mod NUM_PORTS. Next state IDLE.
- mem_rvalid is ignored outside WAIT.
- Latency: request accept to mem_valid is 1 cycle. Minimum transaction is 3 cycles (IDLE, ISSUE with mem_ready=1, WAIT with mem_rvalid=1).
- Requesters must hold req_valid and payload until req_ready. Deasserting req_valid before grant is legal; that channel is simply not selected.
- Non-granted channels see req_ready=0 and resp_valid=0 throughout a transaction.
- Channel ordering: a channel with req_valid held high while its own transaction completes is re-arbitrated in the next IDLE cycle. Fixed mode allows port 0 to starve others; RR mode guarantees service within NUM_PORTS transactions.
- Reset (asynchronous, any state, including ISSUE/WAIT):
  - State goes to IDLE; rr_ptr and g reset to 0; latched request cleared to 0.
  - All outputs (req_ready, resp_valid, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_rdata) read 0 while rst is high.
  - An in-flight transaction is dropped with no response. The memory side must also be reset.
- The req_ready/resp_valid one-hot property holds every cycle.

Test Plan:
- Single read: NUM_PORTS=2, fixed mode, ch0 read addr 0x0000_0100, mem_ready=1 immediately, mem_rvalid after 2 WAIT cycles with rdata 0xDEAD_BEEF -> req_ready[0] pulses in cycle 0; mem_valid in cycle 1 with addr 0x100, we=0; resp_valid=2'b01 with resp_rdata 0xDEAD_BEEF in cycle 4.
- Fixed priority collision: ch0 and ch1 both valid every cycle -> ch0 granted on every transaction; ch1 never receives req_ready.
- Round-robin fairness: RR_MODE=1, NUM_PORTS=4, all four valid continuously -> grant order 0,1,2,3,0; each resp_valid bit asserts exactly once per 4 transactions.
- Backpressure: ch1 write addr 0x20, wdata 0x1234_5678, wstrb 4'b0011, mem_ready held low 5 cycles -> mem_valid and all payload stable for 6 cycles; resp_valid[1] only after mem_rvalid.
- Reset mid-transaction: assert rst while in WAIT -> all outputs 0 immediately (asynchronous); after release a new ch0 request is granted, rr_ptr=0, and the late mem_rvalid pulse from the dropped transaction produces no resp_valid.
- Early withdraw: ch1 raises then drops req_valid while ch0 is in ISSUE -> ch1 is never granted; next IDLE with no req_valid set stays IDLE with mem_valid=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter: merges NUM_PORTS valid/ready requesters onto one
// single-outstanding memory bus using fixed-priority or round-robin selection.
module mem_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RR_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*XLEN-1:0]   req_addr,
  input  logic [NUM_PORTS*XLEN-1:0]   req_wdata,
  input  logic [NUM_PORTS*XLEN/8-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [XLEN-1:0]             resp_rdata,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic                        mem_we,
  output logic [XLEN-1:0]             mem_addr,
  output logic [XLEN-1:0]             mem_wdata,
  output logic [XLEN/8-1:0]           mem_wstrb,
  input  logic                        mem_rvalid,
  input  logic [XLEN-1:0]             mem_rdata
);
  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;

  logic [XLEN-1:0] addr_a  [NUM_PORTS];
  logic [XLEN-1:0] wdata_a [NUM_PORTS];
  logic [SW-1:0]   wstrb_a [NUM_PORTS];

  logic [PW-1:0]   start;
  logic [PW-1:0]   sel;
  logic            found;
  int unsigned     idx;

  // Split the flattened request buses into per-channel views.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*XLEN +: XLEN];
    assign wdata_a[i] = req_wdata[i*XLEN +: XLEN];
    assign wstrb_a[i] = req_wstrb[i*SW +: SW];
  end

  // First valid channel at or after the start pointer, wrapping.
  always_comb begin
    start = (RR_MODE != 0) ? rr_ptr_q : '0;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(start) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req_valid[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    case (state_q)
      ST_IDLE: begin
        // Grant is suppressed while reset is held so outputs read zero.
        if (found && !rst) begin
          req_ready[sel] = 1'b1;
          grant_d        = sel;
          we_d           = req_we[sel];
          addr_d         = addr_a[sel];
          wdata_d        = wdata_a[sel];
          wstrb_d        = wstrb_a[sel];
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          resp_valid[grant_q] = 1'b1;
          resp_rdata          = mem_rdata;
          state_d             = ST_IDLE;
          if (RR_MODE != 0) begin
            rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign mem_valid = (state_q == ST_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-port fixed-priority instance and a
// 4-port round-robin instance driven cycle by cycle with hand-computed values.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Fixed-priority, two channels.
  logic [1:0]  f_req_valid = '0, f_req_ready, f_req_we = '0;
  logic [63:0] f_req_addr = '0, f_req_wdata = '0;
  logic [7:0]  f_req_wstrb = '0;
  logic [1:0]  f_resp_valid;
  logic [31:0] f_resp_rdata;
  logic        f_mem_valid, f_mem_ready = 1'b0, f_mem_we, f_mem_rvalid = 1'b0;
  logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata = '0;
  logic [3:0]  f_mem_wstrb;

  // Round-robin, four channels.
  logic [3:0]   r_req_valid = '0, r_req_ready, r_req_we = '0;
  logic [127:0] r_req_addr = '0, r_req_wdata = '0;
  logic [15:0]  r_req_wstrb = '0;
  logic [3:0]   r_resp_valid;
  logic [31:0]  r_resp_rdata;
  logic         r_mem_valid, r_mem_ready = 1'b0, r_mem_we, r_mem_rvalid = 1'b0;
  logic [31:0]  r_mem_addr, r_mem_wdata, r_mem_rdata = '0;
  logic [3:0]   r_mem_wstrb;

  int cnt [4];

  mem_arbiter #(.XLEN(32), .NUM_PORTS(2), .RR_MODE(0)) dut_fix (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_wstrb(f_req_wstrb),
    .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata),
    .mem_valid(f_mem_valid), .mem_ready(f_mem_ready), .mem_we(f_mem_we),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_wstrb(f_mem_wstrb),
    .mem_rvalid(f_mem_rvalid), .mem_rdata(f_mem_rdata)
  );

  mem_arbiter #(.XLEN(32), .NUM_PORTS(4), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_we(r_req_we),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata), .req_wstrb(r_req_wstrb),
    .resp_valid(r_resp_valid), .resp_rdata(r_resp_rdata),
    .mem_valid(r_mem_valid), .mem_ready(r_mem_ready), .mem_we(r_mem_we),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_wstrb(r_mem_wstrb),
    .mem_rvalid(r_mem_rvalid), .mem_rdata(r_mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_rr_zero(input string tag);
    chk({tag, "_ready"}, 64'(r_req_ready), 64'h0);
    chk({tag, "_resp"}, 64'(r_resp_valid), 64'h0);
    chk({tag, "_rdata"}, 64'(r_resp_rdata), 64'h0);
    chk({tag, "_mvalid"}, 64'(r_mem_valid), 64'h0);
    chk({tag, "_mwe"}, 64'(r_mem_we), 64'h0);
    chk({tag, "_maddr"}, 64'(r_mem_addr), 64'h0);
    chk({tag, "_mwdata"}, 64'(r_mem_wdata), 64'h0);
    chk({tag, "_mwstrb"}, 64'(r_mem_wstrb), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    // Reset state, with requests already pending.
    f_req_valid = 2'b01;
    #2;
    chk("rst_f_ready", 64'(f_req_ready), 64'h0);
    chk("rst_f_mvalid", 64'(f_mem_valid), 64'h0);
    chk("rst_f_maddr", 64'(f_mem_addr), 64'h0);
    chk_rr_zero("rst_r");
    tick();
    tick();
    rst = 1'b0;
    f_req_valid = 2'b00;

    // Single read on ch0.
    tick(); f_req_valid = 2'b01; f_req_we = 2'b00; f_req_addr[31:0] = 32'h0000_0100; f_mem_ready = 1'b1; settle();
    chk("rd_c0_ready", 64'(f_req_ready), 64'h1);
    chk("rd_c0_mvalid", 64'(f_mem_valid), 64'h0);
    tick(); f_req_valid = 2'b00; settle();
    chk("rd_c1_mvalid", 64'(f_mem_valid), 64'h1);
    chk("rd_c1_addr", 64'(f_mem_addr), 64'h100);
    chk("rd_c1_we", 64'(f_mem_we), 64'h0);
    chk("rd_c1_ready", 64'(f_req_ready), 64'h0);
    tick(); f_mem_ready = 1'b0; settle();
    chk("rd_c2_mvalid", 64'(f_mem_valid), 64'h0);
    chk("rd_c2_resp", 64'(f_resp_valid), 64'h0);
    tick(); settle();
    chk("rd_c3_resp", 64'(f_resp_valid), 64'h0);
    tick(); f_mem_rvalid = 1'b1; f_mem_rdata = 32'hDEAD_BEEF; settle();
    chk("rd_c4_resp", 64'(f_resp_valid), 64'h1);
    chk("rd_c4_rdata", 64'(f_resp_rdata), 64'hDEAD_BEEF);
    tick(); f_mem_rvalid = 1'b0; settle();
    chk("rd_c5_resp", 64'(f_resp_valid), 64'h0);
    chk("rd_c5_mvalid", 64'(f_mem_valid), 64'h0);

    // Fixed-priority collision: ch0 wins every time.
    f_req_addr[63:32] = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      tick(); f_mem_rvalid = 1'b0; f_req_valid = 2'b11; f_req_addr[31:0] = 32'h300 + 32'(k); settle();
      chk("col_ready", 64'(f_req_ready), 64'h1);
      tick(); f_mem_ready = 1'b1; settle();
      chk("col_mvalid", 64'(f_mem_valid), 64'h1);
      chk("col_addr", 64'(f_mem_addr), 64'h300 + 64'(k));
      chk("col_ready_issue", 64'(f_req_ready), 64'h0);
      tick(); f_mem_ready = 1'b0; f_mem_rvalid = 1'b1; f_mem_rdata = 32'(k) + 32'h77; settle();
      chk("col_resp", 64'(f_resp_valid), 64'h1);
      chk("col_rdata", 64'(f_resp_rdata), 64'h77 + 64'(k));
    end
    tick(); f_mem_rvalid = 1'b0; f_req_valid = 2'b00; settle();

    // Backpressure on a ch1 write; payload inputs change after accept.
    tick(); f_req_valid = 2'b10; f_req_we = 2'b10; f_req_addr[63:32] = 32'h20;
    f_req_wdata[63:32] = 32'h1234_5678; f_req_wstrb[7:4] = 4'b0011; f_mem_ready = 1'b0; settle();
    chk("bp_ready", 64'(f_req_ready), 64'h2);
    for (int c = 0; c < 6; c++) begin
      tick(); f_req_valid = 2'b00; f_req_addr = '0; f_req_wdata = '0; f_req_wstrb = '0; f_req_we = '0;
      f_mem_ready = (c == 5); f_mem_rvalid = (c == 2); settle();
      chk("bp_mvalid", 64'(f_mem_valid), 64'h1);
      chk("bp_addr", 64'(f_mem_addr), 64'h20);
      chk("bp_wdata", 64'(f_mem_wdata), 64'h1234_5678);
      chk("bp_wstrb", 64'(f_mem_wstrb), 64'h3);
      chk("bp_we", 64'(f_mem_we), 64'h1);
      chk("bp_resp_early", 64'(f_resp_valid), 64'h0);
    end
    tick(); f_mem_ready = 1'b0; f_mem_rvalid = 1'b0; settle();
    chk("bp_wait_mvalid", 64'(f_mem_valid), 64'h0);
    chk("bp_wait_resp", 64'(f_resp_valid), 64'h0);
    tick(); f_mem_rvalid = 1'b1; f_mem_rdata = 32'h0000_AAAA; settle();
    chk("bp_resp", 64'(f_resp_valid), 64'h2);
    tick(); f_mem_rvalid = 1'b0; settle();
    chk("bp_resp_done", 64'(f_resp_valid), 64'h0);

    // Early withdraw of ch1 while ch0 is in ISSUE.
    tick(); f_req_valid = 2'b01; f_req_addr[31:0] = 32'h40; settle();
    chk("ew_ready0", 64'(f_req_ready), 64'h1);
    tick(); f_req_valid = 2'b10; f_mem_ready = 1'b0; settle();
    chk("ew_ready_issue", 64'(f_req_ready), 64'h0);
    chk("ew_mvalid", 64'(f_mem_valid), 64'h1);
    chk("ew_addr", 64'(f_mem_addr), 64'h40);
    tick(); f_req_valid = 2'b00; f_mem_ready = 1'b1; settle();
    chk("ew_ready_issue2", 64'(f_req_ready), 64'h0);
    tick(); f_mem_ready = 1'b0; f_mem_rvalid = 1'b1; settle();
    chk("ew_resp", 64'(f_resp_valid), 64'h1);
    tick(); f_mem_rvalid = 1'b0; settle();
    chk("ew_idle_ready", 64'(f_req_ready), 64'h0);
    chk("ew_idle_mvalid", 64'(f_mem_valid), 64'h0);
    tick(); settle();
    chk("ew_idle2_mvalid", 64'(f_mem_valid), 64'h0);
    chk("ew_idle2_resp", 64'(f_resp_valid), 64'h0);

    // Round-robin fairness with all four channels requesting.
    for (int i = 0; i < 4; i++) r_req_addr[i*32 +: 32] = 32'h1000 + 32'(i);
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      tick(); r_mem_rvalid = 1'b0; r_req_valid = 4'hF; settle();
      chk("rr_ready", 64'(r_req_ready), 64'h1 << g);
      tick(); r_mem_ready = 1'b1; settle();
      chk("rr_addr", 64'(r_mem_addr), 64'h1000 + 64'(g));
      tick(); r_mem_ready = 1'b0; r_mem_rvalid = 1'b1; r_mem_rdata = 32'(g); settle();
      chk("rr_resp", 64'(r_resp_valid), 64'h1 << g);
      for (int i = 0; i < 4; i++) if (r_resp_valid[i]) cnt[i]++;
      if (k == 3) begin
        for (int i = 0; i < 4; i++) chk("rr_once", 64'(cnt[i]), 64'h1);
      end
    end
    tick(); r_mem_rvalid = 1'b0; r_req_valid = 4'h0; settle();

    // Reset while in WAIT; rr_ptr was 1 beforehand.
    tick(); r_req_valid = 4'b1000; r_req_we = 4'b1000; r_req_addr[127:96] = 32'h3000;
    r_req_wdata[127:96] = 32'hCAFE_F00D; r_req_wstrb[15:12] = 4'hF; settle();
    chk("rs_ready3", 64'(r_req_ready), 64'h8);
    tick(); r_req_valid = 4'h0; r_mem_ready = 1'b1; settle();
    chk("rs_mvalid", 64'(r_mem_valid), 64'h1);
    chk("rs_mwe", 64'(r_mem_we), 64'h1);
    tick(); r_mem_ready = 1'b0; settle();
    chk("rs_wait_mvalid", 64'(r_mem_valid), 64'h0);
    r_req_valid = 4'b0011; r_mem_rvalid = 1'b1; r_mem_rdata = 32'h0000_0BAD;
    #1 rst = 1'b1;
    #1;
    chk_rr_zero("rs_async");
    tick(); settle();
    chk_rr_zero("rs_held");
    tick(); rst = 1'b0; settle();
    chk("rs_new_ready", 64'(r_req_ready), 64'h1);
    chk("rs_late_resp", 64'(r_resp_valid), 64'h0);
    tick(); r_mem_rvalid = 1'b0; r_req_valid = 4'h0; r_mem_ready = 1'b1; settle();
    chk("rs_new_mvalid", 64'(r_mem_valid), 64'h1);
    chk("rs_new_addr", 64'(r_mem_addr), 64'h1000);
    chk("rs_new_we", 64'(r_mem_we), 64'h0);
    tick(); r_mem_ready = 1'b0; r_mem_rvalid = 1'b1; r_mem_rdata = 32'h5555_5555; settle();
    chk("rs_new_resp", 64'(r_resp_valid), 64'h1);
    chk("rs_new_rdata", 64'(r_resp_rdata), 64'h5555_5555);
    tick(); r_mem_rvalid = 1'b0; settle();
    chk("rs_done_resp", 64'(r_resp_valid), 64'h0);
    chk("rs_done_mvalid", 64'(r_mem_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
